// File: rtl/mer_meas_ctrl.sv
// Purpose: MER measurement sequencer. It arms on a host start, then accumulates
//          NUM_CYCLES LFSR periods and captures the accumulator results.
// Latency: all status and control outputs are registered. They change one clk
//          edge after the clk_en-qualified cycle that causes the change.
// Backpressure: none. The block advances only on clk_en, and every output holds
//               while clk_en=0.
//
// Optional feature: define MER_MEAS_TIMEOUT_EN to build the ARM/ACCUM watchdog.
// When it is undefined, timeout is tied low and ARM/ACCUM wait indefinitely.
//
// Ports:
//   clk, reset (async, active-high), clk_en (symbol-rate enable)
//   start, abort          host request and abort, both level-sensitive
//   cycle_in              LFSR period-boundary strobe
//   *_in  (18b signed)    accumulator and reference values, sampled in CAPTURE
//   acc_hold, acc_clear   accumulator control
//   busy, done            status
//   *_out (18b signed)    captured results, held until the next CAPTURE
//   meas_count (16b)      number of completed measurements, wraps
//   timeout               sticky watchdog flag
module mer_meas_ctrl #(
  parameter int NUM_CYCLES  = 4,
  parameter int TIMEOUT_LEN = 1048576
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               start,
  input  logic               abort,
  input  logic               cycle_in,
  input  logic signed [17:0] dc_err_in,
  input  logic signed [17:0] sq_err_in,
  input  logic signed [17:0] ref_level_in,
  input  logic signed [17:0] avg_power_in,
  output logic               acc_hold,
  output logic               acc_clear,
  output logic               busy,
  output logic               done,
  output logic signed [17:0] dc_err_out,
  output logic signed [17:0] sq_err_out,
  output logic signed [17:0] ref_level_out,
  output logic signed [17:0] avg_power_out,
  output logic [15:0]        meas_count,
  output logic               timeout
);

  // Elaboration-time parameter range checks
  if (NUM_CYCLES < 1 || NUM_CYCLES > 255) begin : g_bad_num_cycles
    $error("mer_meas_ctrl: NUM_CYCLES must be in 1..255");
  end
  if (TIMEOUT_LEN < 1) begin : g_bad_timeout_len
    $error("mer_meas_ctrl: TIMEOUT_LEN must be at least 1");
  end

  localparam logic [7:0] NUM_CYCLES_L = NUM_CYCLES[7:0];

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    ACCUM   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] pcnt, pcnt_nxt;
  logic [7:0] pcnt_inc;
  logic       hold_nxt, clr_nxt, busy_nxt, done_nxt;
  logic       cap;

`ifdef MER_MEAS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_LEN + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_LEN - 1);
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          tmo_nxt;
`endif

  assign pcnt_inc = pcnt + 8'd1;

  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    hold_nxt  = acc_hold;
    clr_nxt   = 1'b0;           // acc_clear lasts only for the first ACCUM cycle
    busy_nxt  = busy;
    done_nxt  = done;
    cap       = 1'b0;
`ifdef MER_MEAS_TIMEOUT_EN
    tcnt_nxt  = tcnt;
    tmo_nxt   = timeout;
`endif

    case (state)
      IDLE: begin
        // cycle_in is not examined here. A strobe that coincides with start
        // therefore cannot also trigger the ARM exit.
        if (start) begin
          state_nxt = ARM;
          busy_nxt  = 1'b1;
          hold_nxt  = 1'b1;
`ifdef MER_MEAS_TIMEOUT_EN
          tcnt_nxt  = '0;
          tmo_nxt   = 1'b0;
`endif
        end
      end
      ARM: begin
        if (cycle_in) begin
          state_nxt = ACCUM;
          clr_nxt   = 1'b1;
          hold_nxt  = 1'b0;
          pcnt_nxt  = 8'd0;
        end
      end
      ACCUM: begin
        if (cycle_in) begin
          pcnt_nxt = pcnt_inc;
          if (pcnt_inc == NUM_CYCLES_L) begin
            state_nxt = CAPTURE;
            hold_nxt  = 1'b1;
          end
        end
      end
      CAPTURE: begin
        cap       = 1'b1;
        state_nxt = DONE;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
      end
      DONE: begin
        if (!start) begin
          state_nxt = IDLE;
          done_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        hold_nxt  = 1'b1;
      end
    endcase

`ifdef MER_MEAS_TIMEOUT_EN
    // The watchdog spans both ARM and ACCUM. It is cleared only when a start
    // is accepted.
    if (state == ARM || state == ACCUM) begin
      if (tcnt == T_LAST) begin
        state_nxt = IDLE;
        tmo_nxt   = 1'b1;
        busy_nxt  = 1'b0;
        hold_nxt  = 1'b1;
        clr_nxt   = 1'b0;
      end else begin
        tcnt_nxt = tcnt + 1'b1;
      end
    end
`endif

    // Abort overrides everything, including a pending capture
    if (abort) begin
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      hold_nxt  = 1'b1;
      clr_nxt   = 1'b0;
      cap       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pcnt          <= 8'd0;
      acc_hold      <= 1'b1;
      acc_clear     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      dc_err_out    <= '0;
      sq_err_out    <= '0;
      ref_level_out <= '0;
      avg_power_out <= '0;
      meas_count    <= 16'd0;
    end else if (clk_en) begin
      state     <= state_nxt;
      pcnt      <= pcnt_nxt;
      acc_hold  <= hold_nxt;
      acc_clear <= clr_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      if (cap) begin
        dc_err_out    <= dc_err_in;
        sq_err_out    <= sq_err_in;
        ref_level_out <= ref_level_in;
        avg_power_out <= avg_power_in;
        meas_count    <= meas_count + 16'd1;
      end
    end
  end

`ifdef MER_MEAS_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else if (clk_en) begin
      tcnt    <= tcnt_nxt;
      timeout <= tmo_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mer_meas_ctrl.sv
// Purpose: self-checking bench for mer_meas_ctrl, built with NUM_CYCLES=2 and TIMEOUT_LEN=50.
// Latency: inputs are driven on the falling edge. Outputs are sampled 1 ns after the rising edge.
// Backpressure: none. The stimulus is a cycle table followed by hand-written corner sequences.
module tb_mer_meas_ctrl;

  logic clk = 1'b0;
  logic reset, clk_en, start, abort, cycle_in;
  logic signed [17:0] dc_err_in, sq_err_in, ref_level_in, avg_power_in;
  logic acc_hold, acc_clear, busy, done, timeout;
  logic signed [17:0] dc_err_out, sq_err_out, ref_level_out, avg_power_out;
  logic [15:0] meas_count;

  int checks = 0;
  int failures = 0;

  always #20 clk = ~clk;

  mer_meas_ctrl #(.NUM_CYCLES(2), .TIMEOUT_LEN(50)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .abort(abort),
    .cycle_in(cycle_in), .dc_err_in(dc_err_in), .sq_err_in(sq_err_in),
    .ref_level_in(ref_level_in), .avg_power_in(avg_power_in),
    .acc_hold(acc_hold), .acc_clear(acc_clear), .busy(busy), .done(done),
    .dc_err_out(dc_err_out), .sq_err_out(sq_err_out),
    .ref_level_out(ref_level_out), .avg_power_out(avg_power_out),
    .meas_count(meas_count), .timeout(timeout)
  );

  typedef struct {
    logic en, st, ab, cy;
    int   dc, sq, rf, pw;
    logic [4:0] stat;   // {busy, done, acc_hold, acc_clear, timeout}
    int   mc;
    int   edc, esq, erf, epw;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input logic en, st, ab, cy, input int dc, sq, rf, pw,
                              input logic [4:0] stat, input int mc,
                              input int edc, esq, erf, epw);
    vec_t v;
    v.en = en; v.st = st; v.ab = ab; v.cy = cy;
    v.dc = dc; v.sq = sq; v.rf = rf; v.pw = pw;
    v.stat = stat; v.mc = mc;
    v.edc = edc; v.esq = esq; v.erf = erf; v.epw = epw;
    return v;
  endfunction

  function automatic logic [127:0] stat_now();
    return {123'd0, busy, done, acc_hold, acc_clear, timeout};
  endfunction

  function automatic logic [127:0] data_now();
    return {40'd0, dc_err_out, sq_err_out, ref_level_out, avg_power_out, meas_count};
  endfunction

  function automatic logic [127:0] data_exp(input int edc, esq, erf, epw, mc);
    return {40'd0, 18'(edc), 18'(esq), 18'(erf), 18'(epw), 16'(mc)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_data(input int dc, sq, rf, pw);
    dc_err_in = 18'(dc); sq_err_in = 18'(sq); ref_level_in = 18'(rf); avg_power_in = 18'(pw);
  endtask

  task automatic step(input logic en, st, ab, cy);
    @(negedge clk);
    clk_en = en; start = st; abort = ab; cycle_in = cy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_clr, num_clr, hold_rise, done_i, mc_at_done;

    // Cycle table. Expected status is {busy, done, acc_hold, acc_clear, timeout}.
    tbl[0]  = mk(1,0,0,0, 11,22,33,44,           5'b00100, 0, 0,0,0,0);
    tbl[1]  = mk(1,1,0,1, 11,22,33,44,           5'b10100, 0, 0,0,0,0); // strobe ignored
    tbl[2]  = mk(1,0,0,0, 11,22,33,44,           5'b10100, 0, 0,0,0,0);
    tbl[3]  = mk(0,0,0,1, 11,22,33,44,           5'b10100, 0, 0,0,0,0); // clk_en low
    tbl[4]  = mk(1,0,0,1, 11,22,33,44,           5'b10010, 0, 0,0,0,0); // ACCUM entry
    tbl[5]  = mk(1,0,0,0, 11,22,33,44,           5'b10000, 0, 0,0,0,0);
    tbl[6]  = mk(1,0,0,1, 11,22,33,44,           5'b10000, 0, 0,0,0,0); // period 1
    tbl[7]  = mk(0,0,0,1, 11,22,33,44,           5'b10000, 0, 0,0,0,0); // clk_en low
    tbl[8]  = mk(1,0,0,1, -5,1234,100,-200,      5'b10100, 0, 0,0,0,0); // period 2, CAPTURE
    tbl[9]  = mk(1,0,0,0, -5,1234,100,-200,      5'b01100, 1, -5,1234,100,-200);
    tbl[10] = mk(1,1,0,0, 7,8,9,10,              5'b01100, 1, -5,1234,100,-200);
    tbl[11] = mk(1,0,0,0, 7,8,9,10,              5'b00100, 1, -5,1234,100,-200);
    tbl[12] = mk(1,1,0,0, 7,8,9,10,              5'b10100, 1, -5,1234,100,-200);
    tbl[13] = mk(1,0,0,1, 7,8,9,10,              5'b10010, 1, -5,1234,100,-200);
    tbl[14] = mk(1,0,0,1, 7,8,9,10,              5'b10000, 1, -5,1234,100,-200);
    tbl[15] = mk(1,0,1,0, 7,8,9,10,              5'b00100, 1, -5,1234,100,-200); // abort
    tbl[16] = mk(1,1,1,0, 7,8,9,10,              5'b00100, 1, -5,1234,100,-200); // abort beats start
    tbl[17] = mk(1,1,0,0, 7,8,9,10,              5'b10100, 1, -5,1234,100,-200);
    tbl[18] = mk(1,0,0,1, 7,8,9,10,              5'b10010, 1, -5,1234,100,-200);
    tbl[19] = mk(1,0,0,1, 7,8,9,10,              5'b10000, 1, -5,1234,100,-200);
    tbl[20] = mk(1,0,0,1, 7,8,9,10,              5'b10100, 1, -5,1234,100,-200);
    tbl[21] = mk(1,0,0,0, -131072,131071,0,1,    5'b01100, 2, -131072,131071,0,1);
    tbl[22] = mk(1,0,0,0, 5,5,5,5,               5'b00100, 2, -131072,131071,0,1);
    tbl[23] = mk(1,1,0,0, 5,5,5,5,               5'b10100, 2, -131072,131071,0,1);
    tbl[24] = mk(1,0,0,1, 5,5,5,5,               5'b10010, 2, -131072,131071,0,1);
    tbl[25] = mk(1,0,0,1, 5,5,5,5,               5'b10000, 2, -131072,131071,0,1);
    tbl[26] = mk(1,0,0,1, 5,5,5,5,               5'b10100, 2, -131072,131071,0,1);
    tbl[27] = mk(1,0,1,0, 5,5,5,5,               5'b00100, 2, -131072,131071,0,1); // abort in CAPTURE

    // Reset state
    reset = 1'b1; clk_en = 1'b0; start = 1'b0; abort = 1'b0; cycle_in = 1'b0;
    set_data(0, 0, 0, 0);
    #1;
    chk("reset stat", stat_now(), 128'(5'b00100));
    chk("reset data", data_now(), data_exp(0, 0, 0, 0, 0));
    #50;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 28; i++) begin
      set_data(tbl[i].dc, tbl[i].sq, tbl[i].rf, tbl[i].pw);
      step(tbl[i].en, tbl[i].st, tbl[i].ab, tbl[i].cy);
      chk($sformatf("vec%0d stat", i), stat_now(), 128'(tbl[i].stat));
      chk($sformatf("vec%0d data", i), data_exp(0, 0, 0, 0, 0) | data_now(),
          data_exp(tbl[i].edc, tbl[i].esq, tbl[i].erf, tbl[i].epw, tbl[i].mc));
    end

    // Full measurement with cycle_in every 100 symbols
    set_data(21, -21, 321, -321);
    step(1, 1, 0, 0);
    first_clr = -1; num_clr = 0; hold_rise = -1; done_i = -1; mc_at_done = -1;
    for (int i = 1; i <= 350; i++) begin
      step(1, 0, 0, (i % 100) == 0);
      if (acc_clear) begin
        num_clr++;
        if (first_clr < 0) first_clr = i;
      end
      if (first_clr >= 0 && hold_rise < 0 && i > first_clr && acc_hold) hold_rise = i;
      if (done && done_i < 0) begin
        done_i = i;
        mc_at_done = int'(meas_count);
      end
    end
    chk("long acc_clear count", 128'(num_clr), 128'(1));
    chk("long accum entry", 128'(first_clr), 128'(100));
    chk("long capture distance", 128'(hold_rise - first_clr), 128'(200));
    chk("long done symbol", 128'(done_i), 128'(301));
    chk("long meas_count", 128'(mc_at_done), 128'(3));
    chk("long data", data_now(), data_exp(21, -21, 321, -321, 3));

`ifdef MER_MEAS_TIMEOUT_EN
    step(1, 1, 0, 0);
    for (int i = 0; i < 49; i++) step(1, 0, 0, 0);
    chk("timeout before limit", stat_now(), 128'(5'b10100));
    step(1, 0, 0, 0);
    chk("timeout at limit", stat_now(), 128'(5'b00101));
    chk("timeout data", data_now(), data_exp(21, -21, 321, -321, 3));
    step(1, 1, 0, 0);
    chk("timeout cleared by start", stat_now(), 128'(5'b10100));
    step(1, 0, 1, 0);
`else
    step(1, 1, 0, 0);
    for (int i = 0; i < 60; i++) step(1, 0, 0, 0);
    chk("arm waits without watchdog", stat_now(), 128'(5'b10100));
    step(1, 0, 1, 0);
`endif
    chk("idle after watchdog test", stat_now(), 128'(5'b00100));

    // Reset in the middle of ACCUM
    step(1, 1, 0, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("pre-reset accum", stat_now(), 128'(5'b10000));
    @(negedge clk);
    #5 reset = 1'b1;
    #1;
    chk("async reset stat", stat_now(), 128'(5'b00100));
    chk("async reset data", data_now(), data_exp(0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    chk("post-reset no capture stat", stat_now(), 128'(5'b00100));
    chk("post-reset no capture data", data_now(), data_exp(0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
